// File: rtl/regfile_rename.sv
// regfile_rename: architectural register file x0-x31 with per-register rename tags.
// Holds committed values, and for each register whether an in-flight ROB entry will
// produce it and under which ROB index. The decoder renames destinations at issue and
// resolves source operands through two combinational read ports.
//
// Ports:
//   clk_in, rst_in (async, active-low), rdy_in (low = freeze all state)
//   issue_en/issue_rd/issue_rob_id     : destination rename from the decoder
//   rs1_id/rs2_id -> rsX_busy/tag/value : combinational operand lookup
//   write_en/reg_id/rob_id/value_in     : ROB commit port
//   clear_all                           : misprediction flush, clears every busy bit
//
// Optional feature: define REGFILE_COMMIT_BYPASS_EN to forward a matching commit onto
// the read ports in the same cycle (busy=0, value=value_in).

module regfile_rename #(
    parameter int unsigned REG_ID_BIT    = 5,
    parameter int unsigned ROB_WIDTH_BIT = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,

    input  logic                     issue_en,
    input  logic [REG_ID_BIT-1:0]    issue_rd,
    input  logic [ROB_WIDTH_BIT-1:0] issue_rob_id,

    input  logic [REG_ID_BIT-1:0]    rs1_id,
    output logic                     rs1_busy,
    output logic [ROB_WIDTH_BIT-1:0] rs1_tag,
    output logic [31:0]              rs1_value,

    input  logic [REG_ID_BIT-1:0]    rs2_id,
    output logic                     rs2_busy,
    output logic [ROB_WIDTH_BIT-1:0] rs2_tag,
    output logic [31:0]              rs2_value,

    input  logic                     write_en,
    input  logic [REG_ID_BIT-1:0]    reg_id,
    input  logic [ROB_WIDTH_BIT-1:0] rob_id,
    input  logic [31:0]              value_in,

    input  logic                     clear_all
);

    localparam int unsigned NUM_REGS = 1 << REG_ID_BIT;

    logic [31:0]              r_val [NUM_REGS];
    logic [NUM_REGS-1:0]      r_busy;
    logic [ROB_WIDTH_BIT-1:0] r_tag [NUM_REGS];

    logic w_commit_valid;
    logic w_commit_hit;

    // A commit only releases the register if it is the latest producer.
    assign w_commit_valid = write_en && (reg_id != '0);
    assign w_commit_hit   = w_commit_valid && r_busy[reg_id] && (r_tag[reg_id] == rob_id);

    // State update: value write, then busy release, then flush / rename (later wins).
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_val[i] <= '0;
                r_tag[i] <= '0;
            end
            r_busy <= '0;
        end else if (rdy_in) begin
            if (w_commit_valid) begin
                r_val[reg_id] <= value_in;
                if (w_commit_hit) begin
                    r_busy[reg_id] <= 1'b0;
                end
            end
            if (clear_all) begin
                r_busy <= '0;
            end else if (issue_en && (issue_rd != '0)) begin
                r_busy[issue_rd] <= 1'b1;
                r_tag[issue_rd]  <= issue_rob_id;
            end
        end
    end

    // Read port 1; x0 is hardwired to a ready zero.
    always_comb begin
        rs1_busy  = 1'b0;
        rs1_tag   = '0;
        rs1_value = '0;
        if (rs1_id != '0) begin
            rs1_busy  = r_busy[rs1_id];
            rs1_tag   = r_tag[rs1_id];
            rs1_value = r_val[rs1_id];
`ifdef REGFILE_COMMIT_BYPASS_EN
            if (w_commit_hit && (reg_id == rs1_id)) begin
                rs1_busy  = 1'b0;
                rs1_value = value_in;
            end
`endif
        end
    end

    // Read port 2; x0 is hardwired to a ready zero.
    always_comb begin
        rs2_busy  = 1'b0;
        rs2_tag   = '0;
        rs2_value = '0;
        if (rs2_id != '0) begin
            rs2_busy  = r_busy[rs2_id];
            rs2_tag   = r_tag[rs2_id];
            rs2_value = r_val[rs2_id];
`ifdef REGFILE_COMMIT_BYPASS_EN
            if (w_commit_hit && (reg_id == rs2_id)) begin
                rs2_busy  = 1'b0;
                rs2_value = value_in;
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_rename.sv
// Testbench for regfile_rename: directed scenarios followed by randomized traffic,
// all checked against a register-level behavioural model.

module tb_regfile_rename;

    localparam int unsigned REG_ID_BIT    = 5;
    localparam int unsigned ROB_WIDTH_BIT = 4;
    localparam int unsigned NUM_REGS      = 32;

    logic                     clk_in = 1'b0;
    logic                     rst_in;
    logic                     rdy_in;
    logic                     issue_en;
    logic [REG_ID_BIT-1:0]    issue_rd;
    logic [ROB_WIDTH_BIT-1:0] issue_rob_id;
    logic [REG_ID_BIT-1:0]    rs1_id;
    logic                     rs1_busy;
    logic [ROB_WIDTH_BIT-1:0] rs1_tag;
    logic [31:0]              rs1_value;
    logic [REG_ID_BIT-1:0]    rs2_id;
    logic                     rs2_busy;
    logic [ROB_WIDTH_BIT-1:0] rs2_tag;
    logic [31:0]              rs2_value;
    logic                     write_en;
    logic [REG_ID_BIT-1:0]    reg_id;
    logic [ROB_WIDTH_BIT-1:0] rob_id;
    logic [31:0]              value_in;
    logic                     clear_all;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    logic [31:0]              m_val  [NUM_REGS];
    bit                       m_busy [NUM_REGS];
    logic [ROB_WIDTH_BIT-1:0] m_tag  [NUM_REGS];

    regfile_rename #(
        .REG_ID_BIT    (REG_ID_BIT),
        .ROB_WIDTH_BIT (ROB_WIDTH_BIT)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .issue_en     (issue_en),
        .issue_rd     (issue_rd),
        .issue_rob_id (issue_rob_id),
        .rs1_id       (rs1_id),
        .rs1_busy     (rs1_busy),
        .rs1_tag      (rs1_tag),
        .rs1_value    (rs1_value),
        .rs2_id       (rs2_id),
        .rs2_busy     (rs2_busy),
        .rs2_tag      (rs2_tag),
        .rs2_value    (rs2_value),
        .write_en     (write_en),
        .reg_id       (reg_id),
        .rob_id       (rob_id),
        .value_in     (value_in),
        .clear_all    (clear_all)
    );

    always #5 clk_in = ~clk_in;

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) begin
            m_val[i]  = 32'h0;
            m_busy[i] = 1'b0;
            m_tag[i]  = '0;
        end
    endtask

    // One clock edge of the architectural rules: commit, then flush or rename.
    task automatic model_edge();
        if (rdy_in) begin
            if (write_en && reg_id != 0) begin
                m_val[reg_id] = value_in;
                if (m_busy[reg_id] && m_tag[reg_id] == rob_id) m_busy[reg_id] = 1'b0;
            end
            if (clear_all) begin
                for (int i = 0; i < NUM_REGS; i++) m_busy[i] = 1'b0;
            end else if (issue_en && issue_rd != 0) begin
                m_busy[issue_rd] = 1'b1;
                m_tag[issue_rd]  = issue_rob_id;
            end
        end
    endtask

    function automatic bit bypass_hit(input logic [REG_ID_BIT-1:0] id);
`ifdef REGFILE_COMMIT_BYPASS_EN
        return write_en && id != 0 && reg_id == id && m_busy[id] && m_tag[id] == rob_id;
`else
        return (id == 0) && (id != 0);
`endif
    endfunction

    function automatic bit exp_busy(input logic [REG_ID_BIT-1:0] id);
        if (id == 0 || bypass_hit(id)) return 1'b0;
        return m_busy[id];
    endfunction

    function automatic logic [31:0] exp_value(input logic [REG_ID_BIT-1:0] id);
        if (id == 0) return 32'h0;
        if (bypass_hit(id)) return value_in;
        return m_val[id];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive both read ports and compare against the model (tag only matters when busy).
    task automatic check_reads(input string tag, input logic [REG_ID_BIT-1:0] a,
                               input logic [REG_ID_BIT-1:0] b);
        rs1_id = a;
        rs2_id = b;
        #1;
        chk({tag, ".rs1_busy"},  32'(rs1_busy),  32'(exp_busy(a)));
        chk({tag, ".rs1_value"}, rs1_value,      exp_value(a));
        if (exp_busy(a)) chk({tag, ".rs1_tag"}, 32'(rs1_tag), 32'(m_tag[a]));
        chk({tag, ".rs2_busy"},  32'(rs2_busy),  32'(exp_busy(b)));
        chk({tag, ".rs2_value"}, rs2_value,      exp_value(b));
        if (exp_busy(b)) chk({tag, ".rs2_tag"}, 32'(rs2_tag), 32'(m_tag[b]));
    endtask

    task automatic tick();
        @(posedge clk_in);
        model_edge();
        #1;
    endtask

    task automatic idle();
        rdy_in    = 1'b1;
        issue_en  = 1'b0;
        write_en  = 1'b0;
        clear_all = 1'b0;
    endtask

    task automatic do_issue(input logic [REG_ID_BIT-1:0] rd, input logic [ROB_WIDTH_BIT-1:0] t);
        issue_en     = 1'b1;
        issue_rd     = rd;
        issue_rob_id = t;
    endtask

    task automatic do_commit(input logic [REG_ID_BIT-1:0] rd, input logic [ROB_WIDTH_BIT-1:0] t,
                             input logic [31:0] v);
        write_en = 1'b1;
        reg_id   = rd;
        rob_id   = t;
        value_in = v;
    endtask

    initial begin
        rst_in = 1'b0;
        idle();
        issue_rd = '0; issue_rob_id = '0; reg_id = '0; rob_id = '0; value_in = '0;
        rs1_id = '0; rs2_id = '0;
        model_reset();

        // Reset held from time 0, released between edges
        check_reads("reset", 5'd5, 5'd0);
        #10 rst_in = 1'b1;
        #1;

        // Rename then commit
        do_issue(5, 3); tick(); idle();
        check_reads("rename", 5'd5, 5'd0);
        chk("rename.tag_const", 32'(rs1_tag), 32'd3);
        do_commit(5, 3, 32'hDEADBEEF);
        check_reads("commit_cycle", 5'd5, 5'd5);
        tick(); idle();
        check_reads("commit_after", 5'd5, 5'd5);
        chk("commit.value_const", rs1_value, 32'hDEADBEEF);

        // Stale commit keeps younger rename busy
        do_issue(7, 2); tick();
        do_issue(7, 6); tick(); idle();
        do_commit(7, 2, 32'h11); tick(); idle();
        check_reads("stale", 5'd0, 5'd7);
        chk("stale.busy_const", 32'(rs2_busy), 32'd1);
        chk("stale.tag_const", 32'(rs2_tag), 32'd6);
        do_commit(7, 6, 32'h22); tick(); idle();
        check_reads("stale_final", 5'd7, 5'd7);

        // Same-cycle commit and issue on one register
        do_issue(9, 1); tick(); idle();
        do_commit(9, 1, 32'h44); do_issue(9, 4); tick(); idle();
        check_reads("collide", 5'd9, 5'd9);
        chk("collide.tag_const", 32'(rs1_tag), 32'd4);
        chk("collide.value_const", rs1_value, 32'h44);

        // Flush beats a simultaneous issue
        do_commit(8, 0, 32'h88); tick(); idle();
        do_issue(3, 5); tick();
        do_issue(4, 6); tick(); idle();
        clear_all = 1'b1; do_issue(8, 7); tick(); idle();
        check_reads("flush34", 5'd3, 5'd4);
        check_reads("flush8", 5'd8, 5'd8);
        chk("flush.x8_value_const", rs1_value, 32'h88);

        // x0 ignores issue and commit
        do_issue(0, 5); do_commit(0, 5, 32'h99); tick(); idle();
        check_reads("x0", 5'd0, 5'd0);

        // rdy_in low freezes commit, issue and clear
        do_issue(10, 11); tick(); idle();
        rdy_in = 1'b0; do_commit(2, 0, 32'h55); tick(); idle();
        rdy_in = 1'b0; clear_all = 1'b1; do_issue(2, 3); tick(); idle();
        check_reads("pause", 5'd2, 5'd10);
        chk("pause.x2_const", rs1_value, 32'h0);
        chk("pause.x10_busy_const", 32'(rs2_busy), 32'd1);

        // Commit matching a busy tag, observed in the commit cycle
        do_issue(12, 9); tick(); idle();
        do_commit(12, 9, 32'h1234);
        check_reads("bypass", 5'd12, 5'd3);
        tick(); idle();
        check_reads("bypass_after", 5'd12, 5'd12);

        // Randomized traffic on a small register window to force collisions
        for (int c = 0; c < 400; c++) begin
            logic [REG_ID_BIT-1:0] ra, rb;
            rdy_in    = ($urandom_range(0, 9) != 0);
            issue_en  = $urandom_range(0, 1) == 1;
            issue_rd  = 5'($urandom_range(0, 7));
            issue_rob_id = 4'($urandom);
            write_en  = $urandom_range(0, 1) == 1;
            reg_id    = 5'($urandom_range(0, 7));
            rob_id    = ($urandom_range(0, 2) != 0) ? m_tag[reg_id] : 4'($urandom);
            value_in  = $urandom;
            clear_all = ($urandom_range(0, 19) == 0);
            ra = 5'($urandom_range(0, 7));
            rb = ($urandom_range(0, 1) == 1) ? reg_id : 5'($urandom_range(0, 7));
            check_reads("rnd", ra, rb);
            tick();
        end
        idle();

        // Asynchronous reset asserted mid-cycle with live state
        do_issue(6, 2); tick(); idle();
        do_commit(11, 0, 32'hCAFE); tick(); idle();
        #2 rst_in = 1'b0;
        model_reset();
        check_reads("async_rst", 5'd6, 5'd11);
        #3 rst_in = 1'b1;
        #1;
        tick();
        check_reads("post_rst", 5'd5, 5'd6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_rename.md
# regfile_rename

Architectural register file with per-register rename tags: the commit-side endpoint for the reorder buffer's writeback port (`write_en`/`reg_id`/`rob_id`/`value_out`). It holds committed values for x0–x31 and, for each register, whether an in-flight instruction will produce it and under which ROB index. The decoder uses it to rename destinations at issue and to resolve source operands. It sits between decoder, ROB and the RS/LSB operand path.

## Interface
- `REG_ID_BIT`, 5, register index width (32 registers)
- `ROB_WIDTH_BIT`, 4, ROB index width
- `clk_in`  input  1  clock, all state on rising edge
- `rst_in`  input  1  reset, asynchronous, active-low
- `rdy_in`  input  1  when low, no state changes; combinational reads still valid
- `issue_en`  input  1  decoder renames a destination this cycle
- `issue_rd`  input  REG_ID_BIT  destination register of the issuing instruction
- `issue_rob_id`  input  ROB_WIDTH_BIT  ROB slot assigned to it (the ROB's `rob_free_id`)
- `rs1_id` / `rs2_id`  input  REG_ID_BIT  source register indices
- `rs1_busy` / `rs2_busy`  output  1  source awaits an in-flight producer
- `rs1_tag` / `rs2_tag`  output  ROB_WIDTH_BIT  producing ROB index, valid when busy
- `rs1_value` / `rs2_value`  output  32  committed value, valid when not busy
- `write_en`  input  1  ROB commit strobe
- `reg_id`  input  REG_ID_BIT  committed destination
- `rob_id`  input  ROB_WIDTH_BIT  ROB index of the committing entry
- `value_in`  input  32  committed result
- `clear_all`  input  1  misprediction flush from ROB

## Operation
- State per register i: `val[i]` (32b), `busy[i]`, `tag[i]`.
- x0: reads always return busy=0, tag=0, value=0. Issue and commit to x0 are ignored.
- Commit (`write_en`, `reg_id`≠0):
  - `val[reg_id] <= value_in` unconditionally.
  - `busy[reg_id] <= 0` only if `busy[reg_id]` is set and `tag[reg_id]==rob_id`. A stale commit, where a younger instruction has since renamed the register, keeps the register busy.
- Issue (`issue_en`, `issue_rd`≠0): `busy[issue_rd] <= 1`, `tag[issue_rd] <= issue_rob_id`.
- Commit and issue to the same register in the same cycle:
  - Issue wins busy/tag.
  - Commit still writes `val`.
- `clear_all`:
  - Every `busy` is cleared.
  - A commit in the same cycle still writes `val`.
  - An issue in the same cycle is dropped (clear wins).
  - `tag` contents are don't-care after a flush.
- Reads are combinational and reflect registered state before this cycle's issue. An instruction whose rd equals its rs therefore sees the previous mapping.
- `rdy_in` low: issue, commit and clear are all ignored, including their `val` writes.

## Timing
- Reset (`rst_in` low, async): all `val`=0, `busy`=0, `tag`=0. Hence `rs*_busy`=0, `rs*_tag`=0, `rs*_value`=0.
- Reset deasserting mid-stream: the first active edge after release is a normal cycle.
- Read latency 0 (combinational from `rs*_id`).
- Commit and issue effects are visible on reads from the cycle after the edge, except when the bypass is enabled (see Configuration).
- No backpressure. Every strobe is accepted in the cycle it is presented while `rdy_in` is high.
- Tags use no wrap-around arithmetic. Only equality compare is used; all widths are exact, with no extension.

## Configuration
- `REGFILE_COMMIT_BYPASS_EN` defined:
  - When `write_en`, `reg_id==rsX_id`≠0, `busy[rsX_id]` and `tag[rsX_id]==rob_id` all hold, `rsX_busy`=0 and `rsX_value`=`value_in` in the same cycle.
  - This removes the one-cycle gap between commit and operand readiness.
- Undefined: reads show pre-commit state. During the commit cycle the decoder sees busy=1 and obtains the value from the ROB by tag.

## Test plan
- Reset: drive `rst_in` low asynchronously mid-cycle -> all read outputs 0 immediately. After release, read x5 -> busy=0, value=0.
- Rename then commit: issue rd=5 tag=3.
  - Next cycle rs1_id=5 -> busy=1, tag=3.
  - Commit reg 5 rob 3 value 0xDEADBEEF.
  - Next cycle -> busy=0, value=0xDEADBEEF.
- Stale commit:
  - Issue rd=7 tag=2, then issue rd=7 tag=6.
  - Commit reg 7 rob 2 value 0x11 -> rs2 read gives busy=1, tag=6, value=0x11.
  - Commit rob 6 value 0x22 -> busy=0, value=0x22.
- Same-cycle collision:
  - Busy x9 with tag 1.
  - In one cycle commit reg 9 rob 1 value 0x44 and issue rd=9 tag 4 -> next cycle busy=1, tag=4, value=0x44.
- Flush:
  - x3 busy tag 5, x4 busy tag 6.
  - Assert `clear_all` with simultaneous issue rd=8 tag 7 -> next cycle x3, x4, x8 all busy=0. x8 value unchanged.
- x0 and pause:
  - Issue rd=0 and commit reg 0 value 0x99 -> x0 reads 0, not busy.
  - With `rdy_in`=0, commit reg 2 value 0x55 -> x2 unchanged.
  - With the bypass defined, a commit matching a busy tag returns `value_in` combinationally.
